// File: rtl/pmod_7seg_pkg.sv
// Shared segment patterns (bit 6..0 = A..G, 1 = lit) and capture FSM states
// for the PMOD 7-segment display path.
package pmod_7seg_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
  localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
  localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
  localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1110011;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b0011111;
  localparam logic [6:0] SEG_HEX_C = 7'b1001110;
  localparam logic [6:0] SEG_HEX_D = 7'b0111101;
  localparam logic [6:0] SEG_HEX_E = 7'b1001111;
  localparam logic [6:0] SEG_HEX_F = 7'b1000111;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_SAMPLE
  } cap_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the hex segment table; any pattern outside the 16 glyphs is
// flagged illegal.
module seg7_pattern_decode
  import pmod_7seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    case (seg)
      SEG_HEX_0: digit = 4'h0;
      SEG_HEX_1: digit = 4'h1;
      SEG_HEX_2: digit = 4'h2;
      SEG_HEX_3: digit = 4'h3;
      SEG_HEX_4: digit = 4'h4;
      SEG_HEX_5: digit = 4'h5;
      SEG_HEX_6: digit = 4'h6;
      SEG_HEX_7: digit = 4'h7;
      SEG_HEX_8: digit = 4'h8;
      SEG_HEX_9: digit = 4'h9;
      SEG_HEX_A: digit = 4'hA;
      SEG_HEX_B: digit = 4'hB;
      SEG_HEX_C: digit = 4'hC;
      SEG_HEX_D: digit = 4'hD;
      SEG_HEX_E: digit = 4'hE;
      SEG_HEX_F: digit = 4'hF;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmod_7seg_capture.sv
// Recovers the two hex digits shown on a time-multiplexed PMOD 7-segment bus,
// with per-digit valid, illegal-pattern pulse and select-activity timeout.
module pmod_7seg_capture
  import pmod_7seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       select,
  output logic [3:0] numa,
  output logic [3:0] numb,
  output logic       valid_a,
  output logic       valid_b,
  output logic       update,
  output logic       err,
  output logic       stale
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  cap_state_e       state, state_nxt;
  logic [6:0]       seg_r;
  logic             sel_r, sel_prev, sel_edge;
  logic             phase;
  logic [7:0]       settle_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;
  logic             sample_en;
  logic [3:0]       dec_digit;
  logic             dec_legal;

  seg7_pattern_decode u_dec (
    .seg   (seg_r),
    .digit (dec_digit),
    .legal (dec_legal)
  );

  assign sel_edge = sel_r ^ sel_prev;
  assign to_hit   = !sel_edge && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // A select edge always restarts settling, even from S_SAMPLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (sel_edge) state_nxt = S_SETTLE;
      S_SETTLE: if (!sel_edge && settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = sel_edge ? S_SETTLE : S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    sample_en = (state == S_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r      <= '0;
      sel_r      <= 1'b0;
      sel_prev   <= 1'b0;
      phase      <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      seg_r    <= seg;
      sel_r    <= select;
      sel_prev <= sel_r;
      if (sel_edge) begin
        phase      <= sel_r;
        settle_cnt <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
      if (sel_edge)              to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Sample write is last so it overrides a coincident timeout for its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      numa    <= 4'h0;
      numb    <= 4'h0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      update  <= 1'b0;
      err     <= 1'b0;
      stale   <= 1'b0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (sel_edge) begin
        stale <= 1'b0;
      end else if (to_hit) begin
        stale   <= 1'b1;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end
      if (sample_en) begin
        if (dec_legal) begin
          update <= 1'b1;
          if (phase) begin
            numb    <= dec_digit;
            valid_b <= 1'b1;
          end else begin
            numa    <= dec_digit;
            valid_a <= 1'b1;
          end
        end else begin
          err <= 1'b1;
          if (phase) valid_b <= 1'b0;
          else       valid_a <= 1'b0;
        end
      end
    end
  end

endmodule
